// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order write-back FIFO in front of the register file write
// port. Accepts results over valid/ready, drains one entry per cycle into the
// register file, and forwards still-pending values to two read lookups.
module reg_wb_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  wb_stall,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic [DATA_WIDTH-1:0] fwd_data2,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_s;
  logic                  store_s;

  // Status flags and the handshake derive only from registered occupancy.
  always_comb begin
    full_s   = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
    in_ready = !full_s;
    // Writes to register 0 complete the handshake but are never stored.
    store_s  = in_valid && !full_s && (in_addr != '0);
    rf_wen   = !empty && !wb_stall;
    rf_waddr = empty ? '0 : addr_q[head_q];
    rf_wdata = empty ? '0 : data_q[head_q];
  end

  // Next-state for pointers and occupancy; enqueue+dequeue leaves count alone.
  always_comb begin
    head_d  = rf_wen  ? head_q + PTR_W'(1) : head_q;
    tail_d  = store_s ? tail_q + PTR_W'(1) : tail_q;
    case ({store_s, rf_wen})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards every pending entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates every use.
  always_ff @(posedge clk) begin
    if (store_s) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end else begin
      addr_q[tail_q] <= addr_q[tail_q];
      data_q[tail_q] <= data_q[tail_q];
    end
  end

  // Forwarding: walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             occ;
    logic             m1;
    logic             m2;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = '0;
    occ       = 1'b0;
    m1        = 1'b0;
    m2        = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx       = head_q + PTR_W'(i);
      occ       = (CNT_W'(i) < count_q);
      m1        = occ && (raddr1 != '0) && (addr_q[idx] == raddr1);
      m2        = occ && (raddr2 != '0) && (addr_q[idx] == raddr2);
      fwd_hit1  = fwd_hit1 | m1;
      fwd_hit2  = fwd_hit2 | m2;
      fwd_data1 = m1 ? data_q[idx] : fwd_data1;
      fwd_data2 = m2 ? data_q[idx] : fwd_data2;
    end
  end

endmodule

// File: doc/reg_wb_queue.md
# reg_wb_queue

Write-back queue that sits in front of the register file write port. It accepts results from the execution stage over a valid/ready handshake and buffers them in a small in-order FIFO. It drains one entry per cycle into the register file's `wen`/`waddr`/`wdata` port. It also offers a forwarding lookup so readers can see values that are still pending in the queue.

## Interface
- `DATA_WIDTH`, default 32: width of a register value.
- `ADDR_WIDTH`, default 5: register index width (32 registers).
- `DEPTH`, default 4: queue entries; must be a power of two, at least 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a result.
- `in_ready`  out  1  queue can accept; equals !full.
- `in_addr`  in  ADDR_WIDTH  destination register.
- `in_data`  in  DATA_WIDTH  result value.
- `wb_stall`  in  1  when high, the head entry is not drained this cycle.
- `rf_wen`  out  1  register file write enable.
- `rf_waddr`  out  ADDR_WIDTH  register file write address (head entry).
- `rf_wdata`  out  DATA_WIDTH  register file write data (head entry).
- `raddr1`, `raddr2`  in  ADDR_WIDTH  forwarding lookup addresses.
- `fwd_hit1`, `fwd_hit2`  out  1  a pending entry targets the looked-up register.
- `fwd_data1`, `fwd_data2`  out  DATA_WIDTH  data from the youngest matching entry; 0 when there is no hit.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `empty`  out  1  count == 0.

## Operation
- Storage: DEPTH entries of {addr, data}, a head pointer, a tail pointer and an occupancy counter.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Enqueue condition: `in_valid && in_ready`. Entry written at the tail, tail advances.
- Address 0 handling: a handshake with `in_addr == 0` completes (accepted) but stores nothing. Tail and count do not change, and nothing is ever written to register 0.
- Dequeue condition: `rf_wen = !empty && !wb_stall`, driven combinationally. `rf_waddr`/`rf_wdata` always show the head entry, or 0 when empty. When `rf_wen` is high, head advances at the edge.
- Simultaneous enqueue and dequeue: count is unchanged. When full, `in_ready` is 0 even if a dequeue happens that cycle; there is no same-cycle pass-through.
- Forwarding, per port:
  - Hit when `raddr != 0` and any occupied entry has a matching address.
  - On multiple matches, the youngest entry (closest to the tail) wins.
  - Lookup is purely combinational over stored entries. `in_data` of the current cycle is not forwarded.
  - The head entry being written this cycle still reports a hit.
- Count rules: increments on a stored enqueue only, decrements on dequeue, and never leaves 0..DEPTH.

## Timing
- Reset (asynchronous, on `resetn` low):
  - Pointers and count go to 0, so `empty`=1, `in_ready`=1, `rf_wen`=0, `rf_waddr`/`rf_wdata`=0.
  - `fwd_hit*`=0, `fwd_data*`=0.
  - Entry contents do not need to be cleared.
- Reset mid-operation: all pending entries are discarded and nothing further is written.
- Latency:
  - An entry accepted at edge N appears on `rf_wen`/`rf_waddr`/`rf_wdata` in cycle N+1 if it reaches the head and `wb_stall` is low.
  - It commits to the register file at edge N+1.
  - Minimum enqueue-to-commit latency is 1 cycle.
- Throughput: one enqueue and one dequeue per cycle.
- Full boundary: `in_ready` falls in the cycle after the DEPTH-th stored enqueue, provided no dequeue occurred. The producer must hold `in_valid`/`in_addr`/`in_data` stable until accepted.
- Empty boundary: `rf_wen` is 0 and `wb_stall` is ignored.
- `in_ready` depends only on registered state, never on `in_valid`.

## Test plan
- Reset then idle: hold `resetn` low for 3 cycles, then release. `in_ready`=1, `empty`=1, `rf_wen`=0 and `fwd_hit1`=0 for `raddr1`=5 throughout.
- Single write:
  - Stimulus: enqueue {addr 3, data 0xDEADBEEF} at edge N, `wb_stall`=0.
  - Cycle N+1: `rf_wen`=1, `rf_waddr`=3, `rf_wdata`=0xDEADBEEF, `fwd_hit1`=1 for `raddr1`=3.
  - Cycle N+2: `empty`=1.
- Fill and drain:
  - Stimulus: `wb_stall`=1, enqueue 4 entries {1,0x11},{2,0x22},{1,0x33},{4,0x44}.
  - While stalled: `count`=4, `in_ready`=0. `raddr1`=1 gives `fwd_data1`=0x33 (youngest wins), `raddr2`=4 gives 0x44.
  - After releasing the stall: writes occur in order 1,2,1,4 on consecutive cycles, then `in_ready`=1.
- Register 0 drop: enqueue {0, 0x55} then {7, 0x66}. The first handshake completes with `count` unchanged. Only one `rf_wen` pulse occurs (addr 7), and `raddr1`=0 never hits.
- Simultaneous enqueue/dequeue: with `count`=2, enqueue and dequeue in the same cycle; `count` stays 2. With `count`=4 and `in_valid`=1, `in_ready`=0 while dequeuing, and the entry is accepted on the next cycle.
- Async reset mid-operation: with 3 entries queued, pulse `resetn` low between clock edges. Outputs clear immediately, no `rf_wen` follows, and a subsequent enqueue of {9,0x99} commits normally.
